// File: rtl/sparse_act_sequencer_if.sv
// sparse_act_sequencer_if: tile control, group input and beat output bundle.
// The stall_cnt signal exists only when SPARSE_SEQ_STALL_CNT_EN is defined.
interface sparse_act_sequencer_if;
    logic        start;
    logic [7:0]  num_groups;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_act;
    logic [3:0]  in_mask;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_act;
    logic [1:0]  out_idx;
    logic        out_last_grp;
    logic        busy;
    logic        done;
`ifdef SPARSE_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    // driver side (tile issuer / downstream consumer)
    modport master (
        output start, num_groups, in_valid, in_act, in_mask, out_ready,
        input  in_ready, out_valid, out_act, out_idx, out_last_grp, busy, done
`ifdef SPARSE_SEQ_STALL_CNT_EN
        , input stall_cnt
`endif
    );

    // sequencer side
    modport slave (
        input  start, num_groups, in_valid, in_act, in_mask, out_ready,
        output in_ready, out_valid, out_act, out_idx, out_last_grp, busy, done
`ifdef SPARSE_SEQ_STALL_CNT_EN
        , output stall_cnt
`endif
    );
endinterface

// File: rtl/sparse_act_sequencer.sv
// sparse_act_sequencer: walks a tile of 4-lane activation groups and emits
// only the nibbles whose weight-mask bit is set, lowest index first.
// Optional feature macro: SPARSE_SEQ_STALL_CNT_EN adds a saturating count of
// EMIT cycles spent waiting on out_ready.
module sparse_act_sequencer (
    input  logic                    clk,
    input  logic                    rst,
    sparse_act_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, EMIT = 2'd2, DONE = 2'd3} state_t;

    state_t      state, state_nxt;
    logic [7:0]  ngrp_q;
    logic [7:0]  grp_cnt;
    logic [15:0] act_q;
    logic [3:0]  pend_q;
    logic [1:0]  low_idx;
    logic        last_bit;
    logic        more_after_load;

    // lowest set bit of the pending mask selects the next beat
    always_comb begin
        low_idx = 2'd0;
        casez (pend_q)
            4'b???1: low_idx = 2'd0;
            4'b??10: low_idx = 2'd1;
            4'b?100: low_idx = 2'd2;
            4'b1000: low_idx = 2'd3;
            default: low_idx = 2'd0;
        endcase
    end

    assign last_bit        = (pend_q != 4'd0) && ((pend_q & (pend_q - 4'd1)) == 4'd0);
    // group being loaded now is number grp_cnt+1; widened so 255 cannot wrap
    assign more_after_load = ({1'b0, grp_cnt} + 9'd1) < {1'b0, ngrp_q};

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next-state decision
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = (bus.num_groups == 8'd0) ? DONE : LOAD;
            LOAD: if (bus.in_valid) begin
                if (bus.in_mask == 4'd0) state_nxt = more_after_load ? LOAD : DONE;
                else                     state_nxt = EMIT;
            end
            EMIT: if (bus.out_ready && last_bit) state_nxt = (grp_cnt < ngrp_q) ? LOAD : DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // tile length, group counter, group data and pending mask
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ngrp_q  <= 8'd0;
            grp_cnt <= 8'd0;
            act_q   <= 16'd0;
            pend_q  <= 4'd0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    ngrp_q  <= bus.num_groups;
                    grp_cnt <= 8'd0;
                end
                LOAD: if (bus.in_valid) begin
                    act_q   <= bus.in_act;
                    pend_q  <= bus.in_mask;
                    grp_cnt <= grp_cnt + 8'd1;
                end
                EMIT: if (bus.out_ready) pend_q <= pend_q & (pend_q - 4'd1);
                default: ;
            endcase
        end
    end

    // all handshake outputs come from registers only
    assign bus.in_ready     = (state == LOAD);
    assign bus.out_valid    = (state == EMIT);
    assign bus.out_idx      = low_idx;
    assign bus.out_act      = act_q[{low_idx, 2'b00} +: 4];
    assign bus.out_last_grp = last_bit;
    assign bus.busy         = (state != IDLE);
    assign bus.done         = (state == DONE);

`ifdef SPARSE_SEQ_STALL_CNT_EN
    logic [15:0] stall_q;

    // backpressure cycles seen while a beat is offered; saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                             stall_q <= 16'd0;
        else if (state == IDLE && bus.start)                 stall_q <= 16'd0;
        else if (state == EMIT && !bus.out_ready && stall_q != 16'hFFFF)
                                                             stall_q <= stall_q + 16'd1;
    end

    assign bus.stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_sparse_act_sequencer.sv
// tb_sparse_act_sequencer: directed and random tiles against a queue-based
// model of the expected beat stream.
module tb_sparse_act_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [15:0] g_act  [256];
    logic [3:0]  g_mask [256];

    sparse_act_sequencer_if bus ();

    sparse_act_sequencer dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: random out_ready, 1: always ready, 2: hold off 3 cycles per beat
    task automatic run_tile(input int n, input int mode);
        logic [6:0] expq[$];
        logic [6:0] cur, prev_beat;
        logic       prev_stall;
        int gi, cyc, done_cnt, done_cyc, stalls, wcnt, budget;
        expq = {};
        for (int g = 0; g < n; g++)
            for (int k = 0; k < 4; k++)
                if (g_mask[g][k])
                    expq.push_back({((g_mask[g] >> (k + 1)) == 4'd0), 2'(k), 4'((g_act[g] >> (4 * k)) & 16'hF)});
        gi = 0; cyc = 0; done_cnt = 0; done_cyc = -1; stalls = 0; wcnt = 0;
        prev_stall = 1'b0; prev_beat = '0;
        budget = n * 30 + 40;
        while (cyc < budget && done_cnt == 0) begin
            @(negedge clk);
            if (cyc == 0) begin
                bus.start = 1'b1; bus.num_groups = 8'(n);
            end else begin
                bus.start = ($urandom_range(0, 7) == 0); bus.num_groups = 8'($urandom);
            end
            bus.in_valid = (gi < n) && ($urandom_range(0, 3) != 0);
            bus.in_act   = g_act[gi & 255];
            bus.in_mask  = g_mask[gi & 255];
            case (mode)
                0: bus.out_ready = ($urandom_range(0, 2) != 0);
                1: bus.out_ready = 1'b1;
                default: begin
                    if (bus.out_valid) begin
                        bus.out_ready = (wcnt == 3);
                        wcnt = (wcnt == 3) ? 0 : wcnt + 1;
                    end else begin
                        bus.out_ready = 1'b0; wcnt = 0;
                    end
                end
            endcase
            #1;
            if (bus.in_valid && bus.in_ready) gi++;
            cur = {bus.out_last_grp, bus.out_idx, bus.out_act};
            if (bus.out_valid) begin
                if (prev_stall) chk("hold", 32'(cur), 32'(prev_beat));
                if (bus.out_ready) begin
                    if (expq.size() == 0) chk("extra_beat", 32'(cur), 32'hFFFF);
                    else                  chk("beat", 32'(cur), 32'(expq.pop_front()));
                end else stalls++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_beat  = cur;
            if (bus.done) begin done_cnt++; done_cyc = cyc; end
            cyc++;
        end
        chk("done_seen", 32'(done_cnt), 32'd1);
        chk("groups_in", 32'(gi), 32'(n));
        chk("beats_left", 32'(expq.size()), 32'd0);
        if (n == 0) chk("done_lat", 32'(done_cyc), 32'd1);
`ifdef SPARSE_SEQ_STALL_CNT_EN
        chk("stall_cnt", 32'(bus.stall_cnt), 32'(stalls));
`endif
        @(negedge clk);
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        #1;
        chk("done_pulse", 32'(bus.done), 32'd0);
        chk("busy_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic found;
        bus.start = 1'b0; bus.num_groups = '0; bus.in_valid = 1'b0;
        bus.in_act = '0; bus.in_mask = '0; bus.out_ready = 1'b0;
        #3;
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_act", 32'(bus.out_act), 0);
        chk("rst_out_idx", 32'(bus.out_idx), 0);
        chk("rst_last", 32'(bus.out_last_grp), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        @(posedge clk); #2 rst = 1'b0;

        // two beats from one group; start on first edge after reset release
        g_act[0] = 16'hDCBA; g_mask[0] = 4'b1010;
        run_tile(1, 1);

        // empty groups around a single-bit group
        g_act[0] = 16'h4321; g_mask[0] = 4'b0000;
        g_act[1] = 16'h4321; g_mask[1] = 4'b0001;
        g_act[2] = 16'h4321; g_mask[2] = 4'b0000;
        run_tile(3, 1);

        // zero-length tile
        run_tile(0, 1);

        // full mask with backpressure on every beat
        g_act[0] = 16'h8765; g_mask[0] = 4'b1111;
        run_tile(1, 2);
`ifdef SPARSE_SEQ_STALL_CNT_EN
        chk("stall_12", 32'(bus.stall_cnt), 32'd12);
`endif

        // reset in the middle of emitting a group
        g_act[0] = 16'($urandom); g_mask[0] = 4'b1100;
        @(negedge clk);
        bus.start = 1'b1; bus.num_groups = 8'd1; bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_act = g_act[0]; bus.in_mask = g_mask[0];
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            if (bus.out_valid && bus.out_idx == 2'd3) found = 1'b1;
        end
        chk("rst_reach", 32'(found), 32'd1);
        bus.out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 0);
        @(negedge clk);
        rst = 1'b0; bus.in_valid = 1'b0;
        run_tile(1, 1);

        // random tiles
        for (int t = 0; t < 20; t++) begin
            int n;
            n = $urandom_range(1, 12);
            for (int g = 0; g < n; g++) begin
                g_act[g]  = 16'($urandom);
                g_mask[g] = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom);
            end
            run_tile(n, t % 3);
        end

        // longest tile: counter must reach 255 without wrapping
        for (int g = 0; g < 255; g++) begin
            g_act[g]  = 16'($urandom);
            g_mask[g] = 4'($urandom);
        end
        run_tile(255, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
